free_list: RTL
==============

# free_list

Physical-register free list for the rename stage. Sits directly upstream of the RAT: each cycle it presents the next free physical register ID, which the RAT consumes as its allocated ID for a renamed destination. The commit stage returns the previous mapping of each retired destination, its old RD PRF ID, to the tail. The list is a circular FIFO of PRF IDs with a show-ahead head, occupancy tracking and overflow detection.

## Interface
Parameters:
- PRF_COUNT, 256: number of physical registers; IDs are 8 bits.
- ARCH_REGS, 32: architectural registers; PRF IDs 0..ARCH_REGS-1 are mapped at reset and never start in the list.
- DEPTH, PRF_COUNT-ARCH_REGS (224): list capacity, derived and not overridden.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Alloc_Req  in  1  rename requests one PRF ID this cycle. Deasserted by the rename stage when RD is x0.
- Alloc_Valid  out  1  a free ID is available; equals !Empty.
- Allocated_PRF_ID  out  8  ID at the head, combinational (show-ahead); feeds the RAT allocated-ID input.
- Release_Valid  in  1  commit returns one ID this cycle.
- Release_PRF_ID  in  8  returned ID, which is the old RD PRF ID of the retiring instruction.
- Free_Count  out  8  number of IDs currently in the list, 0..DEPTH.
- Empty  out  1  Free_Count == 0.
- Full  out  1  Free_Count == DEPTH.
- Overflow_Err  out  1  sticky; set when a release is dropped.

## Operation
- Storage: DEPTH x 8-bit entries, plus Head and Tail indices in 0..DEPTH-1, plus Count.
- Reset state: entry[i] = ARCH_REGS+i for i = 0..DEPTH-1; Head=0; Tail=0; Count=DEPTH; Overflow_Err=0.
- Outputs at reset: Allocated_PRF_ID=32, Alloc_Valid=1, Free_Count=224, Full=1, Empty=0.
- Alloc fire = Alloc_Req && !Empty.
  - On fire, Head advances by 1.
  - Alloc_Req while Empty is ignored: no state change, and the stall belongs to the requester.
- Release accept = Release_Valid && (!Full || alloc fire).
  - On accept, entry[Tail] = Release_PRF_ID and Tail advances by 1.
  - A release while Full with no alloc fire is dropped and sets Overflow_Err. It is cleared only by Reset.
- Count update: +1 on accept only, -1 on fire only, unchanged on both or neither.
- Wrap-around: an index at DEPTH-1 increments to 0. DEPTH is not a power of two, so wrap is an explicit compare, not truncation.
- No validity check on Release_PRF_ID values; any 8-bit ID is accepted, including 0..31 after those have been remapped.

## Timing
- Allocation has zero latency: Allocated_PRF_ID is valid in the same cycle as Alloc_Valid. The RAT samples it on the edge where the fire occurs.
- Release-to-allocate latency is 1 cycle minimum. There is no same-cycle bypass: with Empty and a simultaneous release, the alloc is not granted; the ID becomes available the next cycle.
- Full with simultaneous alloc and release:
  - Both complete.
  - Head and Tail address the same slot. The reader gets the old value and the write lands at the edge.
  - Count stays DEPTH.
- Count and the flags reflect the registered state after each edge. Free_Count, Empty and Full are derived from the Count register, with no extra cycle.
- Reset asserted mid-operation immediately restores the reset state, including the entry contents, regardless of CLK.

## Structure
- Shared package rename_pkg holds:
  - PRF_COUNT, ARCH_REGS and PRF_ID_W=8
  - typedef prf_id_t = logic [7:0]
  - typedef arch_reg_t = logic [4:0]
  - a wrap-increment function for indices modulo DEPTH, reused by a later ROB.
- Single flat module; no sub-module is warranted. Storage is flops, not RAM, because the reset contents are required.

## Test plan
- Reset check: release Reset → Allocated_PRF_ID=32, Free_Count=224, Full=1, Alloc_Valid=1, Overflow_Err=0.
- Allocation sequence: Alloc_Req high for 3 cycles → IDs 32, 33, 34 are presented in turn; Free_Count=221; Full=0.
- Drain and refill:
  - 224 consecutive allocs → Empty=1, Alloc_Valid=0.
  - Alloc_Req held → no Head change.
  - Release ID 5 → next cycle Allocated_PRF_ID=5 and Free_Count=1.
- Wrap-around: drain all, release 224 IDs 0..223, allocate all → IDs return in order 0..223 and Head and Tail both wrap to 0.
- Full boundary:
  - Full, Release_Valid only → dropped; Overflow_Err=1 and stays 1.
  - Full with Alloc_Req and release of ID 7 on the same cycle → alloc gets 32, release accepted, Free_Count stays 224, and ID 7 emerges after 223 further allocs.
- Async reset mid-stream: assert Reset between edges after 10 allocs → outputs return to reset values immediately, and after release the first alloc gives 32.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: PRF sizing, ID types and index helpers.
package rename_pkg;

  localparam int PRF_COUNT = 256;
  localparam int ARCH_REGS = 32;
  localparam int PRF_ID_W  = 8;

  typedef logic [PRF_ID_W-1:0] prf_id_t;
  typedef logic [4:0]          arch_reg_t;

  // Increment a circular-buffer index that wraps at an arbitrary depth.
  // The depth need not be a power of two, so the wrap is an explicit compare.
  function automatic logic [7:0] wrap_inc(input logic [7:0] idx, input logic [7:0] depth);
    return (idx == depth - 8'd1) ? 8'd0 : idx + 8'd1;
  endfunction

endpackage

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free PRF IDs with a
// show-ahead head feeding the RAT and a tail fed by retiring old mappings.
module free_list #(
  parameter int PRF_COUNT = 256,
  parameter int ARCH_REGS = 32
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Alloc_Req,
  output logic       Alloc_Valid,
  output logic [7:0] Allocated_PRF_ID,
  input  logic       Release_Valid,
  input  logic [7:0] Release_PRF_ID,
  output logic [7:0] Free_Count,
  output logic       Empty,
  output logic       Full,
  output logic       Overflow_Err
);
  import rename_pkg::*;

  localparam int         DEPTH   = PRF_COUNT - ARCH_REGS;
  localparam logic [7:0] DEPTH_C = 8'(DEPTH);

  prf_id_t    r_entry [DEPTH];
  logic [7:0] r_head;
  logic [7:0] r_tail;
  logic [7:0] r_count;
  logic       r_overflow;

  logic w_empty;
  logic w_full;
  logic w_fire;
  logic w_accept;
  logic w_drop;

  assign w_empty  = (r_count == 8'd0);
  assign w_full   = (r_count == DEPTH_C);
  // An alloc on the same edge frees the head slot, so a release at Full is
  // still accepted; an empty list never bypasses a same-cycle release.
  assign w_fire   = Alloc_Req && !w_empty;
  assign w_accept = Release_Valid && (!w_full || w_fire);
  assign w_drop   = Release_Valid && !w_accept;

  assign Alloc_Valid      = !w_empty;
  assign Allocated_PRF_ID = r_entry[r_head];
  assign Free_Count       = r_count;
  assign Empty            = w_empty;
  assign Full             = w_full;
  assign Overflow_Err     = r_overflow;

  // Head/tail pointers, occupancy count and sticky overflow flag.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_head     <= 8'd0;
      r_tail     <= 8'd0;
      r_count    <= DEPTH_C;
      r_overflow <= 1'b0;
    end else begin
      if (w_fire)   r_head <= wrap_inc(r_head, DEPTH_C);
      if (w_accept) r_tail <= wrap_inc(r_tail, DEPTH_C);
      case ({w_accept, w_fire})
        2'b10:   r_count <= r_count + 8'd1;
        2'b01:   r_count <= r_count - 8'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry storage; reset reloads every non-architectural PRF ID in order.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= 8'(ARCH_REGS + i);
      end
    end else if (w_accept) begin
      r_entry[r_tail] <= Release_PRF_ID;
    end
  end

endmodule
